// File: rtl/alt_vipvfr121_prc_burst_read_master.sv
// alt_vipvfr121_prc_burst_read_master: Avalon burst read master feeding a FIFO unpacked into narrow lanes.
// Define ALT_VIPVFR121_PRC_BURST_BOUNDARY_EN to keep bursts inside MAX_BURST-word-aligned windows.
module alt_vipvfr121_prc_burst_read_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int UNPACKED_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int BURST_WIDTH = 6,
  parameter int RDATA_FIFO_DEPTH = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_length,
  output logic [UNPACKED_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      discard,
  output logic [ADDR_WIDTH-1:0]     av_address,
  output logic [BURST_WIDTH-1:0]    av_burstcount,
  output logic                      av_read,
  input  logic [DATA_WIDTH-1:0]     av_readdata,
  input  logic                      av_readdatavalid,
  input  logic                      av_waitrequest
);
  localparam int RATIO = DATA_WIDTH / UNPACKED_WIDTH;
  localparam int MAX_BURST = 2 ** (BURST_WIDTH - 1);
  localparam int BSH = $clog2(DATA_WIDTH / 8);
  localparam int LB = BURST_WIDTH - 1;
  localparam int PW = $clog2(RDATA_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {IDLE, CALC, WAIT_SPACE, ISSUE} state_t;
  state_t state, state_n;

  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [BURST_WIDTH-1:0] blen, blen_base;
  logic [CW-1:0]          outstanding, count;
  logic [PW-1:0]          wp, rp;
  logic [IW-1:0]          idx;
  logic [DATA_WIDTH-1:0]  mem [RDATA_FIFO_DEPTH];
  logic space, accept, issue, beat, pop, last_lane;

  assign blen_base = remaining < LEN_WIDTH'(MAX_BURST) ? remaining[BURST_WIDTH-1:0] : BURST_WIDTH'(MAX_BURST);
`ifdef ALT_VIPVFR121_PRC_BURST_BOUNDARY_EN
  logic [BURST_WIDTH-1:0] room;
  assign room = BURST_WIDTH'(MAX_BURST) - BURST_WIDTH'(addr[BSH +: LB]);
  assign blen = room < blen_base ? room : blen_base;
`else
  assign blen = blen_base;
`endif

  // Reserve FIFO room for every word already requested so read data can never overflow it.
  assign space = (CW+1)'(count) + (CW+1)'(outstanding) + (CW+1)'(blen) <= (CW+1)'(RDATA_FIFO_DEPTH);
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign av_read = state == ISSUE;
  assign av_address = addr;
  assign av_burstcount = blen;
  assign issue = av_read && !av_waitrequest;
  assign beat = av_readdatavalid && outstanding != '0;
  assign out_valid = count != '0;
  assign last_lane = idx == IW'(RATIO - 1);
  assign pop = out_valid && (discard || (out_ready && last_lane));
  assign out_data = mem[rp][idx*UNPACKED_WIDTH +: UNPACKED_WIDTH];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = cmd_valid ? CALC : IDLE;
      CALC:       state_n = remaining == '0 ? IDLE : space ? ISSUE : WAIT_SPACE;
      WAIT_SPACE: state_n = space ? ISSUE : WAIT_SPACE;
      ISSUE:      state_n = av_waitrequest ? ISSUE : remaining == LEN_WIDTH'(blen) ? IDLE : CALC;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      outstanding <= '0;
      count <= '0;
      wp <= '0;
      rp <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr <= cmd_addr;
        remaining <= cmd_length;
      end else if (issue) begin
        addr <= addr + (ADDR_WIDTH'(blen) << BSH);
        remaining <= remaining - LEN_WIDTH'(blen);
      end
      outstanding <= outstanding + (issue ? CW'(blen) : '0) - CW'(beat);
      wp <= wp + PW'(beat);
      rp <= rp + PW'(pop);
      count <= count + CW'(beat) - CW'(pop);
      if (out_valid)
        idx <= (discard || (out_ready && last_lane)) ? '0 : idx + IW'(out_ready);
    end
  end

  always_ff @(posedge clock)
    if (beat) mem[wp] <= av_readdata;
endmodule
